// File: rtl/aes_key_expand_128.sv
// ---------------------------------------------------------------------------
// aes_key_expand_128
//
// Sequential AES-128 key schedule generator. A 128-bit cipher key is captured
// on a start pulse and round keys 0..10 are emitted one per accepted
// handshake, so the downstream cipher core can pull them at its own pace.
// Only the current round key is held; no schedule RAM is kept.
//
// Handshake: round_key/rk_index are presented while rk_valid is high and
// stay stable until the cycle in which rk_valid && rk_ready (the transfer
// cycle); the next key appears in the following cycle. rk_valid never
// depends combinationally on rk_ready.
//
// Ports
//   clk        in   1    sole clock, rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    begin expansion of key_in (sampled only in IDLE)
//   key_in     in   128  cipher key, byte 0 at [127:120]
//   busy       out  1    expansion in progress (EMIT or FIN)
//   rk_valid   out  1    round_key / rk_index valid
//   rk_ready   in   1    consumer accepts current round key
//   rk_index   out  4    round number of round_key, 0..10
//   round_key  out  128  current round key, same byte order as key_in
//   done       out  1    one-cycle pulse after round key 10 is accepted
//   dbg_state  out  2    FSM state (0 IDLE, 1 EMIT, 2 FIN) for checkers
// ---------------------------------------------------------------------------
module aes_key_expand_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'd10;

  // AES forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255-x)*8, and 255-x == ~x for an 8-bit x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   rk_q,    rk_d;
  logic [3:0]     idx_q,   idx_d;
  logic [7:0]     rcon_q,  rcon_d;

  // ---------------------------------------------------------------------
  // Next round key datapath
  // ---------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_key;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];

  // RotWord: [a0,a1,a2,a3] -> [a1,a2,a3,a0], a0 being the top byte.
  assign rot_word = {w3[23:0], w3[31:24]};

  // Four parallel S-box lookups form SubWord.
  for (genvar b = 0; b < 4; b++) begin : g_subword
    assign sub_word[8*b +: 8] = sbox(rot_word[8*b +: 8]);
  end

  assign t_word = sub_word ^ {rcon_q, 24'h000000};

  // Each word chains off the freshly computed previous word.
  assign w0_n = w0 ^ t_word;
  assign w1_n = w1 ^ w0_n;
  assign w2_n = w2 ^ w1_n;
  assign w3_n = w3 ^ w2_n;

  assign next_key = {w0_n, w1_n, w2_n, w3_n};

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rk_d    = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_FIN;
          end else begin
            rk_d   = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state only. The key and index are
  // masked outside EMIT so idle/finished cycles show zeros.
  // ---------------------------------------------------------------------
  assign busy      = (state_q != ST_IDLE);
  assign rk_valid  = (state_q == ST_EMIT);
  assign done      = (state_q == ST_FIN);
  assign round_key = rk_valid ? rk_q  : '0;
  assign rk_index  = rk_valid ? idx_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_128
//
// Bench for aes_key_expand_128. Expected round keys are pushed to exp_q when
// an expansion is started and popped as the DUT transfers them.
// ---------------------------------------------------------------------------
module tb_aes_key_expand_128;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         done;
  logic [1:0]   dbg_state;

  aes_key_expand_128 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_index  (rk_index),
    .round_key (round_key),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference data ----------------
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  // FIPS-197 Appendix A.1 key schedule, rounds 0..10.
  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // ---------------- scoreboard ----------------
  // Entry: {key_known, index, key}. Rounds with key_known=0 check index only.
  logic [132:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_fips();
    for (int k = 0; k < 11; k++)
      exp_q.push_back({1'b1, 4'(k), fips_rk[k]});
  endtask

  task automatic push_zero();
    for (int k = 0; k < 11; k++) begin
      if (k == 0)       exp_q.push_back({1'b1, 4'(k), ZERO_KEY});
      else if (k == 1)  exp_q.push_back({1'b1, 4'(k), ZERO_RK1});
      else if (k == 10) exp_q.push_back({1'b1, 4'(k), ZERO_RK10});
      else              exp_q.push_back({1'b0, 4'(k), 128'h0});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_exp(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check_eq("busy_after_start", 128'(busy), 128'd1);
  endtask

  // Consume keys until the DUT returns to IDLE. ready_pct sets the chance of
  // rk_ready per cycle; junk drives random start/key_in while busy.
  task automatic run_keys(input int ready_pct, input bit junk);
    int guard;
    int done_cnt;
    int first_valid;
    logic [132:0] front;
    guard       = 0;
    done_cnt    = 0;
    first_valid = -1;
    while (guard < 300) begin
      rk_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      if (junk) begin
        start  = 1'($urandom_range(0, 1));
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (!busy && done_cnt > 0) break;
      if (done) begin
        done_cnt++;
        if (ready_pct >= 100)
          check_eq("done_latency", 128'(cyc - first_valid), 128'd11);
      end
      if (rk_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          check_eq("extra_key_index", 128'(rk_index), 128'd15);
        end else begin
          front = exp_q[0];
          check_eq(rk_ready ? "rk_index" : "stall_rk_index",
                   128'(rk_index), 128'(front[131:128]));
          if (front[132])
            check_eq(rk_ready ? "round_key" : "stall_round_key",
                     round_key, front[127:0]);
          if (rk_ready) void'(exp_q.pop_front());
        end
      end
      tick();
      guard++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    check_eq("expansion_timeout", 128'(guard >= 300), 128'd0);
    check_eq("done_count", 128'(done_cnt), 128'd1);
    check_eq("keys_left", 128'(exp_q.size()), 128'd0);
    if (ready_pct >= 100 && first_valid >= 0)
      check_eq("idle_latency", 128'(cyc - first_valid), 128'd12);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},      128'(busy),      128'd0);
    check_eq({tag, "_rk_valid"},  128'(rk_valid),  128'd0);
    check_eq({tag, "_done"},      128'(done),      128'd0);
    check_eq({tag, "_rk_index"},  128'(rk_index),  128'd0);
    check_eq({tag, "_round_key"}, round_key,       128'd0);
    check_eq({tag, "_state"},     128'(dbg_state), 128'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // FIPS key, consumer always ready.
    push_fips();
    start_exp(FIPS_KEY);
    run_keys(100, 1'b0);

    // Back-to-back: start in the first IDLE cycle after done, all-zero key.
    push_zero();
    start_exp(ZERO_KEY);
    run_keys(100, 1'b0);

    // Random backpressure around 50%.
    push_fips();
    start_exp(FIPS_KEY);
    run_keys(50, 1'b0);

    // Spurious start pulses with other keys during EMIT and FIN.
    push_fips();
    start_exp(FIPS_KEY);
    run_keys(60, 1'b1);

    // Reset in the middle of the expansion, at round 5.
    start_exp(FIPS_KEY);
    rk_ready = 1'b1;
    guard = 0;
    while (!(rk_valid && rk_index == 4'd5) && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("abort_reach_round5", 128'(guard >= 20), 128'd0);
    check_eq("abort_round5_key", round_key, fips_rk[5]);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    rk_ready = 1'b0;
    check_all_zero("abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("no_done_after_abort", 128'(done), 128'd0);
    end

    // Fresh start after the abort must begin again from round 0 / rcon 01.
    push_fips();
    start_exp(FIPS_KEY);
    run_keys(100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_128.md
# aes_key_expand_128

Sequential AES-128 key schedule generator that sits directly upstream of the multicycle `aes_128` cipher core. It accepts a 128-bit cipher key on a start pulse and emits round keys 0 through 10 one at a time over a valid/ready handshake, so the core consumes them at its own pace. One round key is computed per accepted handshake. No 176-byte schedule RAM is kept.

## Interface
- No parameters. Key size is fixed at 128 bits, 10 rounds.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin expansion of `key_in`. Sampled only in IDLE.
- `key_in`  in  128  cipher key. Byte 0 is [127:120], FIPS-197 column-major order.
- `busy`  out  1  high from the cycle after `start` is accepted until the return to IDLE.
- `rk_valid`  out  1  `round_key` and `rk_index` are valid.
- `rk_ready`  in  1  consumer accepts the current round key.
- `rk_index`  out  4  round number of `round_key`, 0..10.
- `round_key`  out  128  current round key, same byte order as `key_in`.
- `done`  out  1  one-cycle pulse after round key 10 is accepted.

## Operation
- Registers:
  - state (IDLE, EMIT, FIN)
  - `rk_q[127:0]`
  - `idx_q[3:0]`
  - `rcon_q[7:0]`
- Reset (`rst`=1 at a clock edge):
  - state=IDLE, `rk_q`=0, `idx_q`=0, `rcon_q`=8'h01.
  - All outputs 0: `busy`, `rk_valid`, `done`, `rk_index`, `round_key`.
- Reset has priority over every other input. It aborts an expansion in progress, with no `done` pulse.
- IDLE:
  - On `start`=1: `rk_q`<=`key_in`, `idx_q`<=0, `rcon_q`<=8'h01, then go to EMIT.
  - On `start`=0: stay in IDLE.
- EMIT:
  - `rk_valid`=1, `busy`=1, `round_key`=`rk_q`, `rk_index`=`idx_q`.
  - Handshake occurs when `rk_valid`&&`rk_ready`.
  - Handshake with `idx_q`<10: `rk_q`<=next_key(`rk_q`,`rcon_q`), `idx_q`<=`idx_q`+1, `rcon_q`<=xtime(`rcon_q`).
  - Handshake with `idx_q`==10: go to FIN.
  - No handshake: all registers hold. `round_key` and `rk_index` stay stable while `rk_valid` is high.
- FIN: `done`=1, `busy`=1, `rk_valid`=0, then unconditionally go to IDLE.
- `start` in EMIT or FIN is ignored. `key_in` is only sampled in the IDLE cycle where `start`=1.
- next_key, with words w0..w3 where w0=[127:96]:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - RotWord: [a0,a1,a2,a3] becomes [a1,a2,a3,a0]
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
- SubWord uses four combinational AES forward S-box instances inside the block.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00). This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
- All XOR arithmetic is 128-bit with no carries. `idx_q` never exceeds 10.

## Timing
- `start` accepted at edge N: `rk_valid`=1, `rk_index`=0 from cycle N+1.
- With `rk_ready` held at 1:
  - Key k is presented in cycle N+1+k.
  - `done` is high in cycle N+12.
  - Back in IDLE, `busy`=0, in cycle N+13.
  - A new `start` is accepted in cycle N+13 at the earliest.
- Throughput is one round key per cycle. Latency from a handshake to the next key is 1 cycle.
- Outputs are registered or decoded from state only. There is no combinational path from `rk_ready` to any output.
- `rst` asserted mid-EMIT: the next cycle shows all outputs 0 and state IDLE.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → round 0 = key, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; `done` exactly once, 11 cycles after the first `rk_valid`.
- Key 00..00 → round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random `rk_ready` backpressure (~50%) with the FIPS key → the same 11 keys in order; `round_key` and `rk_index` unchanged during every stall cycle.
- `start` pulsed with a different `key_in` during EMIT and FIN → ignored; the sequence matches the first key.
- `rst` asserted at `rk_index`=5 → next cycle all outputs 0, no `done`. A fresh `start` then restarts from round 0 with `rcon`=01, giving a correct round 1 key.
- Back-to-back: `start` in the first IDLE cycle after `done` → second expansion correct.
